// File: rtl/vldst_pkg.sv
// rtl/vldst_pkg.sv - shared types, constants and helpers for the vector LSU request queue
package vldst_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_ADDR_BITS      = 32;
  localparam int unsigned DEF_BLOCK_ID_START = 5;
  localparam int unsigned DEF_MICROOP_WIDTH  = 7;
  localparam int unsigned DEF_TICKET_WIDTH   = 4;
  localparam int unsigned DEF_SIZE_WIDTH     = 3;

  // microop[4:3] encodes the access class; this value marks a store
  localparam logic [1:0] STORE_OPCODE = 2'b11;

  typedef struct packed {
    logic [DEF_ADDR_BITS-1:0]     address;
    logic [DEF_DATA_WIDTH-1:0]    data;
    logic [DEF_TICKET_WIDTH-1:0]  ticket;
    logic [DEF_MICROOP_WIDTH-1:0] microop;
    logic [DEF_SIZE_WIDTH-1:0]    size;
    logic                         is_store;
  } vldst_entry_t;

  function automatic logic is_store(input logic [DEF_MICROOP_WIDTH-1:0] microop);
    return microop[4:3] == STORE_OPCODE;
  endfunction

  function automatic logic [DEF_ADDR_BITS-DEF_BLOCK_ID_START-1:0] block_id(
    input logic [DEF_ADDR_BITS-1:0] addr
  );
    return addr[DEF_ADDR_BITS-1:DEF_BLOCK_ID_START];
  endfunction

endpackage

// File: rtl/vldst_block_match.sv
// rtl/vldst_block_match.sv - compares one address's block ID against N tagged addresses
module vldst_block_match #(
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned BLOCK_ID_START = 5,
  parameter int unsigned N              = 8
) (
  input  logic [ADDR_BITS-1:0]   addr_i,
  input  logic [N*ADDR_BITS-1:0] ent_addr_i,
  input  logic [N-1:0]           ent_valid_i,
  output logic [N-1:0]           hit_o
);

  localparam int unsigned BID_W = ADDR_BITS - BLOCK_ID_START;

  // a hit needs a valid slot whose block ID equals the probe's block ID
  always_comb begin
    hit_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      hit_o[i] = ent_valid_i[i] &&
                 (ent_addr_i[i*ADDR_BITS+BLOCK_ID_START +: BID_W] ==
                  addr_i[ADDR_BITS-1:BLOCK_ID_START]);
    end
  end

endmodule

// File: rtl/vldst_req_queue.sv
// rtl/vldst_req_queue.sv - in-order vector load/store request queue with fetched tracking; VLDST_CONFLICT_EN adds store-to-load block conflict detect
module vldst_req_queue
  import vldst_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_BITS      = 32,
  parameter int unsigned BLOCK_ID_START = 5,
  parameter int unsigned MICROOP_WIDTH  = 7,
  parameter int unsigned TICKET_WIDTH   = 4,
  parameter int unsigned SIZE_WIDTH     = 3,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned UPD_PORTS      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [ADDR_BITS-1:0]           write_address,
  input  logic [DATA_WIDTH-1:0]          write_data,
  input  logic [TICKET_WIDTH-1:0]        write_ticket,
  input  logic [MICROOP_WIDTH-1:0]       write_microop,
  input  logic [SIZE_WIDTH-1:0]          write_size,
  input  logic [UPD_PORTS-1:0]           valid_update_i,
  input  logic [UPD_PORTS*ADDR_BITS-1:0] update_address_i,
  input  logic                           flush_i,
  input  logic                           pop,
  output logic                           head_is_store,
  output logic                           head_is_fetched,
  output logic [ADDR_BITS-1:0]           head_address,
  output logic [DATA_WIDTH-1:0]          head_data,
  output logic [MICROOP_WIDTH-1:0]       head_microop,
  output logic [TICKET_WIDTH-1:0]        head_ticket,
  output logic [SIZE_WIDTH-1:0]          head_size,
  output logic                           write_conflict_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           valid_o,
  output logic                           ready_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // payload storage, deliberately not reset
  logic [ADDR_BITS-1:0]     addr_q    [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q    [DEPTH];
  logic [TICKET_WIDTH-1:0]  ticket_q  [DEPTH];
  logic [MICROOP_WIDTH-1:0] microop_q [DEPTH];
  logic [SIZE_WIDTH-1:0]    size_q    [DEPTH];
  logic [DEPTH-1:0]         store_q;

  // control state
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] fetched_q, fetched_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic                   push_ok;
  logic                   pop_ok;
  logic                   wr_is_store;
  logic [DEPTH*ADDR_BITS-1:0] addr_flat;
  logic [DEPTH-1:0]       upd_hit [UPD_PORTS];
  logic [DEPTH-1:0]       upd_any;
  logic [UPD_PORTS-1:0]   bypass_hit;

  assign ready_o     = (count_q != FULL_COUNT);
  assign valid_o     = (count_q != '0);
  assign count_o     = count_q;
  assign push_ok     = push & ready_o;
  assign pop_ok      = pop & valid_o;
  assign wr_is_store = is_store(write_microop);

  // flatten stored addresses for the block comparators
  always_comb begin
    addr_flat = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      addr_flat[i*ADDR_BITS +: ADDR_BITS] = addr_q[i];
    end
  end

  // one comparator bank per fill/update port against every live entry
  for (genvar p = 0; p < int'(UPD_PORTS); p++) begin : g_upd
    vldst_block_match #(
      .ADDR_BITS      (ADDR_BITS),
      .BLOCK_ID_START (BLOCK_ID_START),
      .N              (DEPTH)
    ) u_upd_match (
      .addr_i      (update_address_i[p*ADDR_BITS +: ADDR_BITS]),
      .ent_addr_i  (addr_flat),
      .ent_valid_i (valid_q & {DEPTH{valid_update_i[p]}}),
      .hit_o       (upd_hit[p])
    );
  end

  // fold per-port hits into one set-fetched vector
  always_comb begin
    upd_any = '0;
    for (int p = 0; p < int'(UPD_PORTS); p++) begin
      upd_any = upd_any | upd_hit[p];
    end
  end

  // incoming request against this cycle's update ports, so a fill racing the push is not lost
  vldst_block_match #(
    .ADDR_BITS      (ADDR_BITS),
    .BLOCK_ID_START (BLOCK_ID_START),
    .N              (UPD_PORTS)
  ) u_bypass_match (
    .addr_i      (write_address),
    .ent_addr_i  (update_address_i),
    .ent_valid_i (valid_update_i),
    .hit_o       (bypass_hit)
  );

`ifdef VLDST_CONFLICT_EN
  logic [DEPTH-1:0] conflict_hit;

  vldst_block_match #(
    .ADDR_BITS      (ADDR_BITS),
    .BLOCK_ID_START (BLOCK_ID_START),
    .N              (DEPTH)
  ) u_conflict_match (
    .addr_i      (write_address),
    .ent_addr_i  (addr_flat),
    .ent_valid_i (valid_q & store_q),
    .hit_o       (conflict_hit)
  );

  assign write_conflict_o = push & ~wr_is_store & (|conflict_hit);
`else
  assign write_conflict_o = 1'b0;
`endif

  // next-state for pointers, occupancy and per-entry flags; flush overrides everything
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    valid_d   = valid_q;
    fetched_d = fetched_q | upd_any;
    if (flush_i) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      valid_d   = '0;
      fetched_d = '0;
    end else begin
      if (pop_ok) begin
        valid_d[head_q]   = 1'b0;
        fetched_d[head_q] = 1'b0;
        head_d            = head_q + 1'b1;
      end
      // a reused slot must not inherit a stale update hit, only the bypass result
      if (push_ok) begin
        valid_d[tail_q]   = 1'b1;
        fetched_d[tail_q] = |bypass_hit;
        tail_d            = tail_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      fetched_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      fetched_q <= fetched_d;
    end
  end

  // payload write at the tail on an accepted, non-flushed push
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) begin
      addr_q[tail_q]    <= write_address;
      data_q[tail_q]    <= write_data;
      ticket_q[tail_q]  <= write_ticket;
      microop_q[tail_q] <= write_microop;
      size_q[tail_q]    <= write_size;
      store_q[tail_q]   <= wr_is_store;
    end
  end

  assign head_address    = addr_q[head_q];
  assign head_data       = data_q[head_q];
  assign head_ticket     = ticket_q[head_q];
  assign head_microop    = microop_q[head_q];
  assign head_size       = size_q[head_q];
  assign head_is_store   = valid_q[head_q] & store_q[head_q];
  assign head_is_fetched = valid_q[head_q] & fetched_q[head_q];

  // flag requests that the queue silently drops
  always_ff @(posedge clk) begin
    if (rst_n && !flush_i) begin
      assert (!(push && !ready_o)) else $warning("push ignored while queue full");
      assert (!(pop && !valid_o)) else $warning("pop ignored while queue empty");
    end
  end

endmodule

// File: tb/tb_vldst_req_queue.sv
// tb/tb_vldst_req_queue.sv - directed self-checking bench for vldst_req_queue
module tb_vldst_req_queue;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [3:0]  write_ticket;
  logic [6:0]  write_microop;
  logic [2:0]  write_size;
  logic [1:0]  valid_update_i;
  logic [63:0] update_address_i;
  logic        flush_i;
  logic        pop;
  logic        head_is_store;
  logic        head_is_fetched;
  logic [31:0] head_address;
  logic [31:0] head_data;
  logic [6:0]  head_microop;
  logic [3:0]  head_ticket;
  logic [2:0]  head_size;
  logic        write_conflict_o;
  logic [3:0]  count_o;
  logic        valid_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

`ifdef VLDST_CONFLICT_EN
  localparam logic CONFLICT_EXP = 1'b1;
`else
  localparam logic CONFLICT_EXP = 1'b0;
`endif

  vldst_req_queue dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .push             (push),
    .write_address    (write_address),
    .write_data       (write_data),
    .write_ticket     (write_ticket),
    .write_microop    (write_microop),
    .write_size       (write_size),
    .valid_update_i   (valid_update_i),
    .update_address_i (update_address_i),
    .flush_i          (flush_i),
    .pop              (pop),
    .head_is_store    (head_is_store),
    .head_is_fetched  (head_is_fetched),
    .head_address     (head_address),
    .head_data        (head_data),
    .head_microop     (head_microop),
    .head_ticket      (head_ticket),
    .head_size        (head_size),
    .write_conflict_o (write_conflict_o),
    .count_o          (count_o),
    .valid_o          (valid_o),
    .ready_o          (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push           = 1'b0;
    pop            = 1'b0;
    flush_i        = 1'b0;
    valid_update_i = 2'b00;
  endtask

  task automatic set_push(input logic [31:0] a, input logic st);
    push          = 1'b1;
    write_address = a;
    write_data    = a ^ 32'h5a5a_0000;
    write_ticket  = a[8:5];
    write_microop = st ? 7'b0011000 : 7'b0000001;
    write_size    = 3'd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    write_address = '0; write_data = '0; write_ticket = '0;
    write_microop = '0; write_size = '0; update_address_i = '0;
    repeat (3) step();
    total++; if (count_o !== 4'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", ready_o); end
    total++; if (head_is_fetched !== 1'b0 || head_is_store !== 1'b0) begin
      bad++; $display("FAIL reset_head_flags got %b%b want 00", head_is_fetched, head_is_store); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      set_push(32'h100 + 32 * i, 1'b0);
      step();
    end
    idle();
    total++; if (count_o !== 4'd8) begin bad++; $display("FAIL fill_count got %0d want 8", count_o); end
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL fill_ready got %b want 0", ready_o); end
    set_push(32'h999, 1'b0);
    step();
    idle();
    total++; if (count_o !== 4'd8) begin bad++; $display("FAIL ninth_push_count got %0d want 8", count_o); end
    for (int i = 0; i < 8; i++) begin
      exp = 32'h100 + 32 * i;
      total++; if (head_address !== exp) begin bad++; $display("FAIL drain_addr[%0d] got %h want %h", i, head_address, exp); end
      total++; if (head_data !== (exp ^ 32'h5a5a_0000) || head_ticket !== exp[8:5]) begin
        bad++; $display("FAIL drain_payload[%0d] got %h/%h want %h/%h", i, head_data, head_ticket, exp ^ 32'h5a5a_0000, exp[8:5]); end
      pop = 1'b1;
      step();
      pop = 1'b0;
    end
    total++; if (count_o !== 4'd0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL drain_empty got count=%0d valid=%b want 0/0", count_o, valid_o); end
  endtask

  task automatic test_update();
    set_push(32'h500, 1'b0); step();
    set_push(32'h240, 1'b0); step();
    idle();
    valid_update_i   = 2'b10;
    update_address_i = {32'h25C, 32'h0};
    step();
    idle();
    total++; if (head_address !== 32'h500 || head_is_fetched !== 1'b0) begin
      bad++; $display("FAIL upd_other got %h/%b want 500/0", head_address, head_is_fetched); end
    pop = 1'b1; step(); idle();
    total++; if (head_address !== 32'h240 || head_is_fetched !== 1'b1) begin
      bad++; $display("FAIL upd_hit got %h/%b want 240/1", head_address, head_is_fetched); end
    total++; if (head_is_store !== 1'b0) begin bad++; $display("FAIL upd_store got %b want 0", head_is_store); end
    pop = 1'b1; step(); idle();
  endtask

  task automatic test_bypass();
    set_push(32'h300, 1'b0);
    valid_update_i   = 2'b01;
    update_address_i = {32'h0, 32'h31F};
    step();
    idle();
    total++; if (head_address !== 32'h300 || head_is_fetched !== 1'b1) begin
      bad++; $display("FAIL bypass_hit got %h/%b want 300/1", head_address, head_is_fetched); end
    pop = 1'b1;
    set_push(32'h340, 1'b0);
    valid_update_i   = 2'b01;
    update_address_i = {32'h0, 32'h31F};
    step();
    idle();
    total++; if (head_address !== 32'h340 || head_is_fetched !== 1'b0 || count_o !== 4'd1) begin
      bad++; $display("FAIL bypass_miss got %h/%b/%0d want 340/0/1", head_address, head_is_fetched, count_o); end
    pop = 1'b1; step(); idle();
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 3; i++) begin
      set_push(32'h600 + 32 * i, 1'b0);
      step();
    end
    idle();
    total++; if (count_o !== 4'd3) begin bad++; $display("FAIL pp_pre_count got %0d want 3", count_o); end
    set_push(32'h660, 1'b0);
    pop = 1'b1;
    step();
    idle();
    total++; if (count_o !== 4'd3 || head_address !== 32'h620) begin
      bad++; $display("FAIL pp_both got %0d/%h want 3/620", count_o, head_address); end
    repeat (3) begin pop = 1'b1; step(); end
    idle();
    total++; if (count_o !== 4'd0) begin bad++; $display("FAIL pp_drain got %0d want 0", count_o); end
  endtask

  task automatic test_wrap();
    logic [31:0] sb[$];
    logic        do_push, do_pop, push_ok, pop_ok;
    for (int i = 0; i < 20; i++) begin
      do_push = (i % 5 != 3);
      do_pop  = (i % 5 == 2) || (i % 5 == 3);
      push_ok = do_push && (sb.size() < 8);
      pop_ok  = do_pop && (sb.size() > 0);
      if (do_push) set_push(32'h800 + 32 * i, 1'b0);
      pop = do_pop;
      step();
      idle();
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) sb.push_back(32'h800 + 32 * i);
      total++; if (count_o !== 4'(sb.size())) begin bad++; $display("FAIL wrap_count[%0d] got %0d want %0d", i, count_o, sb.size()); end
      if (sb.size() > 0) begin
        total++; if (head_address !== sb[0]) begin bad++; $display("FAIL wrap_head[%0d] got %h want %h", i, head_address, sb[0]); end
      end
    end
    while (sb.size() > 0) begin
      total++; if (head_address !== sb[0]) begin bad++; $display("FAIL wrap_drain got %h want %h", head_address, sb[0]); end
      pop = 1'b1; step(); idle();
      void'(sb.pop_front());
    end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL wrap_empty got %b want 0", valid_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_push(32'hA00 + 32 * i, 1'b0);
      step();
    end
    idle();
    total++; if (count_o !== 4'd5) begin bad++; $display("FAIL flush_pre got %0d want 5", count_o); end
    set_push(32'hF00, 1'b0);
    flush_i = 1'b1;
    step();
    idle();
    total++; if (count_o !== 4'd0 || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_state got %0d/%b/%b want 0/0/1", count_o, valid_o, ready_o); end
    set_push(32'hABC0, 1'b0);
    step();
    idle();
    total++; if (count_o !== 4'd1 || head_address !== 32'hABC0) begin
      bad++; $display("FAIL flush_after got %0d/%h want 1/abc0", count_o, head_address); end
    pop = 1'b1; step(); idle();
  endtask

  task automatic test_conflict();
    set_push(32'h400, 1'b1);
    #1;
    total++; if (write_conflict_o !== 1'b0) begin bad++; $display("FAIL conf_store got %b want 0", write_conflict_o); end
    step();
    set_push(32'h408, 1'b0);
    #1;
    total++; if (write_conflict_o !== CONFLICT_EXP) begin bad++; $display("FAIL conf_hit got %b want %b", write_conflict_o, CONFLICT_EXP); end
    step();
    set_push(32'h420, 1'b0);
    #1;
    total++; if (write_conflict_o !== 1'b0) begin bad++; $display("FAIL conf_miss got %b want 0", write_conflict_o); end
    step();
    idle();
    total++; if (count_o !== 4'd3 || head_is_store !== 1'b1) begin
      bad++; $display("FAIL conf_queue got %0d/%b want 3/1", count_o, head_is_store); end
    repeat (3) begin pop = 1'b1; step(); end
    idle();
  endtask

  task automatic test_async_reset();
    set_push(32'hC00, 1'b0); step();
    set_push(32'hC20, 1'b0); step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (count_o !== 4'd0 || valid_o !== 1'b0) begin
      bad++; $display("FAIL async_reset got %0d/%b want 0/0", count_o, valid_o); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_update();
    test_bypass();
    test_push_pop();
    test_wrap();
    test_flush();
    test_conflict();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
